// File: rtl/ccff_bitstream_loader.sv
// ccff_bitstream_loader: streams bitstream bytes LSB-first onto the configuration chain head with a registered shift enable
module ccff_bitstream_loader #(
  parameter int CHAIN_LEN = 20,
  parameter int TIMEOUT = 16
) (
  input  logic CK,
  input  logic RST,
  input  logic start,
  input  logic s_valid,
  input  logic [7:0] s_data,
  output logic s_ready,
  output logic ccff_head,
  output logic prog_en,
  output logic busy,
  output logic done,
  output logic error,
  output logic [$clog2(CHAIN_LEN+1)-1:0] bit_count
);
  localparam int NUM_WORDS = (CHAIN_LEN + 7) / 8;
  localparam int BW = $clog2(CHAIN_LEN + 1);
  localparam int WW = $clog2(NUM_WORDS + 1);
  localparam int IW = $clog2(TIMEOUT + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(CHAIN_LEN - 1);
  localparam logic [WW-1:0] WORDS = WW'(NUM_WORDS);
  localparam logic [WW-1:0] LAST_WORD = WW'(NUM_WORDS - 1);
  localparam logic [3:0] TAIL_BITS = 4'(CHAIN_LEN - 8 * (NUM_WORDS - 1));
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, LOAD, DONE, ERROR} state_t;
  state_t state;
  logic [7:0] shreg;
  logic [3:0] bits_left;
  logic [WW-1:0] words_taken;
  logic [IW-1:0] idle_cnt;
  logic more, accept;
  always_comb begin
    more = words_taken < WORDS;
    s_ready = state == LOAD && bits_left <= 4'd1 && more;
    accept = s_valid && s_ready;
    busy = state == LOAD;
  end
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      shreg <= '0;
      bits_left <= '0;
      words_taken <= '0;
      idle_cnt <= '0;
      ccff_head <= 1'b0;
      prog_en <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
      bit_count <= '0;
    end else if (state != LOAD) begin
      prog_en <= 1'b0;
      if (start) begin
        state <= LOAD;
        bit_count <= '0;
        words_taken <= '0;
        bits_left <= '0;
        idle_cnt <= '0;
        done <= 1'b0;
        error <= 1'b0;
      end
    end else begin
      prog_en <= bits_left != 4'd0;
      if (bits_left != 4'd0) begin
        ccff_head <= shreg[0];
        shreg <= shreg >> 1;
        bits_left <= bits_left - 4'd1;
        bit_count <= bit_count + BW'(1);
        if (bit_count == LAST_BIT) begin
          state <= DONE;
          done <= 1'b1;
        end
      end
      // a new byte only lands while the previous one is on its last bit, so it overrides the shift update
      if (accept) begin
        shreg <= s_data;
        words_taken <= words_taken + WW'(1);
        bits_left <= words_taken == LAST_WORD ? TAIL_BITS : 4'd8;
        idle_cnt <= '0;
      end else if (bits_left == 4'd0 && !s_valid && more) begin
        idle_cnt <= idle_cnt + IW'(1);
        if (idle_cnt == IDLE_LAST) begin
          state <= ERROR;
          error <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// tb_ccff_bitstream_loader: randomized scoreboard bench; expected chain bits are queued at load start and popped on every prog_en cycle
module tb_ccff_bitstream_loader;
  localparam int CL = 20;
  localparam int NW = (CL + 7) / 8;
  logic CK = 1'b0;
  logic RST = 1'b1;
  logic start = 1'b0, s_valid = 1'b0;
  logic [7:0] s_data = '0;
  logic s_ready, ccff_head, prog_en, busy, done, error;
  logic [4:0] bit_count;
  logic e_start = 1'b0, e_valid = 1'b0;
  logic [7:0] e_data = '0;
  logic e8_ready, e8_head, e8_pen, e8_busy, e8_done, e8_err;
  logic [3:0] e8_cnt;
  logic e1_ready, e1_head, e1_pen, e1_busy, e1_done, e1_err;
  logic [0:0] e1_cnt;
  int checks = 0, failures = 0;
  int run = 0, max_run = 0, accepts = 0;
  int e8_pulses = 0, e1_pulses = 0, e8_acc = 0, e1_acc = 0;
  logic [7:0] e8_cap = '0;
  logic e1_cap = 1'b0;
  bit exp_q[$];
  logic [7:0] bytes [NW];

  ccff_bitstream_loader #(.CHAIN_LEN(CL), .TIMEOUT(16)) dut (
    .CK(CK), .RST(RST), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .ccff_head(ccff_head), .prog_en(prog_en), .busy(busy),
    .done(done), .error(error), .bit_count(bit_count));
  ccff_bitstream_loader #(.CHAIN_LEN(8), .TIMEOUT(16)) dut8 (
    .CK(CK), .RST(RST), .start(e_start), .s_valid(e_valid), .s_data(e_data),
    .s_ready(e8_ready), .ccff_head(e8_head), .prog_en(e8_pen), .busy(e8_busy),
    .done(e8_done), .error(e8_err), .bit_count(e8_cnt));
  ccff_bitstream_loader #(.CHAIN_LEN(1), .TIMEOUT(16)) dut1 (
    .CK(CK), .RST(RST), .start(e_start), .s_valid(e_valid), .s_data(e_data),
    .s_ready(e1_ready), .ccff_head(e1_head), .prog_en(e1_pen), .busy(e1_busy),
    .done(e1_done), .error(e1_err), .bit_count(e1_cnt));

  always #5 CK = ~CK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge CK) begin
    if (s_valid && s_ready) accepts++;
    if (e_valid && e8_ready) e8_acc++;
    if (e_valid && e1_ready) e1_acc++;
  end

  // monitor: every shifted bit must match the head of the expected queue
  always @(negedge CK) begin
    if (!busy) chk("ready_outside_load", s_ready, 0);
    if (prog_en) begin
      if (exp_q.size() == 0) chk("extra_bit", 1, 0);
      else chk("head_bit", ccff_head, exp_q.pop_front());
      run++;
      if (run > max_run) max_run = run;
    end else run = 0;
    if (e8_pen) begin
      e8_cap[e8_pulses % 8] = e8_head;
      e8_pulses++;
    end
    if (e1_pen) begin
      e1_cap = e1_head;
      e1_pulses++;
    end
  end

  task automatic push_expected();
    for (int i = 0; i < CL; i++) exp_q.push_back(bytes[i / 8][i % 8]);
  endtask

  task automatic pulse_start();
    @(negedge CK) start = 1'b1;
    @(negedge CK) start = 1'b0;
  endtask

  task automatic run_load(input int gap_lo, input int gap_hi, input bit stray, input bit gap_free);
    int a0, g, n;
    push_expected();
    a0 = accepts;
    max_run = 0;
    pulse_start();
    chk("busy_after_start", busy, 1);
    chk("count_cleared", bit_count, 0);
    chk("done_cleared", done, 0);
    chk("error_cleared", error, 0);
    for (int k = 0; k < NW; k++) begin
      g = $urandom_range(gap_hi, gap_lo);
      n = 0;
      while (1) begin
        if (s_ready) begin
          if (g > 0) begin
            g--;
            s_valid = 1'b0;
          end else begin
            s_data = bytes[k];
            s_valid = 1'b1;
            break;
          end
        end
        if (++n > 100) begin
          chk("ready_timeout", 0, 1);
          break;
        end
        @(negedge CK);
        start = stray && $urandom_range(3, 0) == 0;
      end
      @(negedge CK);
      start = 1'b0;
    end
    s_valid = 1'b0;
    n = 0;
    while (!done && n < 100) begin
      @(negedge CK);
      n++;
    end
    #1;
    chk("done", done, 1);
    chk("bit_count_final", bit_count, CL);
    chk("error_final", error, 0);
    chk("busy_final", busy, 0);
    chk("accept_count", accepts - a0, NW);
    chk("queue_drained", exp_q.size(), 0);
    if (gap_free) chk("gap_free_run", max_run, CL);
    else if (gap_lo > 0) chk("throttled_run", max_run, 8);
  endtask

  initial begin
    int n, a0;
    logic [7:0] b;
    #1;
    chk("rst_prog_en", prog_en, 0);
    chk("rst_head", ccff_head, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_bit_count", bit_count, 0);
    chk("rst_ready", s_ready, 0);
    repeat (2) @(negedge CK);
    RST = 1'b0;
    bytes[0] = 8'hA5; bytes[1] = 8'h3C; bytes[2] = 8'hF9;
    run_load(0, 0, 0, 1);
    // stray valid while DONE must not be taken
    a0 = accepts;
    s_valid = 1'b1;
    s_data = 8'h5A;
    repeat (4) @(negedge CK);
    #1;
    chk("done_ready", s_ready, 0);
    chk("done_no_accept", accepts - a0, 0);
    chk("done_sticky", done, 1);
    s_valid = 1'b0;
    for (int k = 0; k < NW; k++) bytes[k] = 8'($urandom);
    run_load(3, 3, 1, 0);
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < NW; k++) bytes[k] = 8'($urandom);
      run_load(0, 4, 1, 0);
    end
    // starvation after a single byte
    bytes[0] = 8'($urandom);
    for (int i = 0; i < 8; i++) exp_q.push_back(bytes[0][i]);
    pulse_start();
    s_data = bytes[0];
    s_valid = 1'b1;
    @(negedge CK);
    s_valid = 1'b0;
    n = 0;
    while (!error && n < 100) begin
      @(negedge CK);
      n++;
    end
    #1;
    chk("starve_cycles", n, 24);
    chk("starve_error", error, 1);
    chk("starve_busy", busy, 0);
    chk("starve_bit_count", bit_count, 8);
    chk("starve_prog_en", prog_en, 0);
    chk("starve_done", done, 0);
    chk("starve_queue", exp_q.size(), 0);
    for (int k = 0; k < NW; k++) bytes[k] = 8'($urandom);
    run_load(0, 2, 0, 0);
    // asynchronous reset in the middle of a load
    b = 8'($urandom);
    for (int k = 0; k < NW; k++) bytes[k] = b;
    push_expected();
    pulse_start();
    s_data = b;
    s_valid = 1'b1;
    n = 0;
    while (bit_count != 5'd11 && n < 100) begin
      @(negedge CK);
      n++;
    end
    chk("reached_11", bit_count, 11);
    #2 RST = 1'b1;
    #1;
    chk("arst_prog_en", prog_en, 0);
    chk("arst_head", ccff_head, 0);
    chk("arst_busy", busy, 0);
    chk("arst_bit_count", bit_count, 0);
    chk("arst_ready", s_ready, 0);
    exp_q.delete();
    s_valid = 1'b0;
    repeat (3) @(negedge CK);
    RST = 1'b0;
    for (int k = 0; k < NW; k++) bytes[k] = 8'($urandom);
    run_load(0, 2, 0, 0);
    // single-byte and single-bit chains
    e_data = 8'($urandom);
    e_valid = 1'b1;
    @(negedge CK) e_start = 1'b1;
    @(negedge CK) e_start = 1'b0;
    n = 0;
    while (!(e8_done && e1_done) && n < 50) begin
      @(negedge CK);
      n++;
    end
    repeat (3) @(negedge CK);
    #1;
    chk("e8_done", e8_done, 1);
    chk("e8_bit_count", e8_cnt, 8);
    chk("e8_pulses", e8_pulses, 8);
    chk("e8_bits", e8_cap, e_data);
    chk("e8_ready_after", e8_ready, 0);
    chk("e8_accepts", e8_acc, 1);
    chk("e8_error", e8_err, 0);
    chk("e1_done", e1_done, 1);
    chk("e1_bit_count", e1_cnt, 1);
    chk("e1_pulses", e1_pulses, 1);
    chk("e1_bit", e1_cap, e_data[0]);
    chk("e1_ready_after", e1_ready, 0);
    chk("e1_accepts", e1_acc, 1);
    e_valid = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ccff_bitstream_loader.md
Name: ccff_bitstream_loader

Overview:
- Programming-side controller for the fabric's configuration chain (the CCFF chain of dffr cells).
- Accepts bitstream bytes on a valid/ready stream and serializes them onto the chain head, one bit per cycle, with a registered shift-enable.
- Counts exactly CHAIN_LEN bits, then flags completion. Aborts with an error if the upstream stream starves.
- Sits between the bitstream source (host interface / ROM reader) and the ccff_head/prog_clock gating of the fabric top.

Parameters:
- CHAIN_LEN, 20, total number of configuration bits in the chain (>=1).
- TIMEOUT, 16, starvation limit: consecutive idle cycles waiting for a byte in LOAD before abort (>=1).
- NUM_WORDS, (CHAIN_LEN+7)/8, derived, never overridden: bytes consumed per load.

Ports:
- CK  input  1  clock; all state on rising edge.
- RST  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to begin a load.
- s_valid  input  1  byte available.
- s_data  input  8  bitstream byte, shifted LSB first.
- s_ready  output  1  byte accepted when s_valid && s_ready.
- ccff_head  output  1  serial data to chain head (registered).
- prog_en  output  1  chain shifts at the next CK edge when high (registered).
- busy  output  1  high in LOAD.
- done  output  1  sticky; all CHAIN_LEN bits shifted.
- error  output  1  sticky; starvation timeout.
- bit_count  output  $clog2(CHAIN_LEN+1)  bits shifted so far in the current load.

Behaviour:
- Reset (async, immediate): state=IDLE. All outputs 0: s_ready, ccff_head, prog_en, busy, done, error, bit_count. Internal shift register, bits_left, words_taken and idle counter also cleared.
- Reset mid-LOAD abandons the load immediately. The chain holds a partial image; no recovery is attempted.
- State IDLE/DONE/ERROR, start=1:
  - Next state LOAD.
  - Clear bit_count, words_taken, bits_left and the idle counter.
  - Clear done and error in the same edge.
- State IDLE/DONE/ERROR, start=0: state holds and outputs hold; prog_en=0.
- start while in LOAD is ignored.
- State LOAD, handshake:
  - s_ready = (bits_left<=1) && (words_taken<NUM_WORDS). Combinational from state; independent of s_valid.
  - On accept: shreg<=s_data, words_taken++.
  - bits_left<=8 for normal bytes. For the last byte (words_taken==NUM_WORDS-1): bits_left<=CHAIN_LEN-8*(NUM_WORDS-1). Excess high bits of the last byte are discarded, never shifted.
- State LOAD, shifting:
  - Each cycle with bits_left>0: ccff_head<=shreg[0], prog_en<=1, shreg>>=1, bits_left--, bit_count++.
  - Cycles with bits_left==0: prog_en<=0, ccff_head holds.
- Shifting and accepting in the same cycle is legal: the last bit of the current byte goes out while the new byte loads. Back-to-back bytes therefore give a gap-free 1 bit/cycle.
- Latency: byte accepted at edge t puts bit0 on ccff_head with prog_en=1 after edge t+1.
- Completion: the edge that makes bit_count==CHAIN_LEN moves to DONE and sets done=1. prog_en is 1 for that final bit and 0 from the next cycle.
- Starvation:
  - The idle counter increments each LOAD cycle with bits_left==0 && !s_valid && words_taken<NUM_WORDS.
  - It clears on any accept.
  - When it reaches TIMEOUT: state=ERROR, error=1, prog_en=0, s_ready=0.
  - bit_count freezes at its value at abort.
- busy=1 exactly while state==LOAD.
- s_valid outside LOAD is never accepted (s_ready=0).
- s_data is sampled only on accept.

Test Plan:
- Gap-free load, CHAIN_LEN=20: start; bytes 0xA5, 0x3C, 0xF9 presented continuously with s_valid=1 -> 20 consecutive prog_en=1 cycles. Head sequence is 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0, 1,0,0,1 (upper nibble of 0xF9 discarded). done=1 the cycle after the final shift; bit_count=20; exactly 3 accepts.
- Throttled source: insert 3 idle cycles between bytes -> prog_en drops for those cycles, head bit order unchanged, done still reached at bit_count=20, error=0.
- Starvation, TIMEOUT=16: send one byte, then hold s_valid=0 -> after 8 shifts and 16 idle cycles, error=1, busy=0, bit_count=8, prog_en=0. A further start clears error and restarts from bit_count=0.
- Async reset mid-load: assert RST between CK edges at bit_count=11 -> all outputs 0 immediately, no further prog_en pulses. After release, start reloads cleanly.
- Stray inputs: start pulsed during LOAD has no effect on bit_count. s_valid=1 in IDLE/DONE gives s_ready=0 and no accept.
- Edge CHAIN_LEN=8 and CHAIN_LEN=1: one byte, 8 (resp. 1) shifts, done set, s_ready=0 afterwards even with s_valid held high.
